fifo_rr_router: RTL and testbench

- Downstream consumer of four input FIFO instances; feeds four output FIFO instances.
- Round-robin arbitration among non-empty input FIFOs; pops one word at a time.
- Routes each word to the output FIFO selected by its 2-bit destination field.
- Honours each output FIFO's almost-full pause by holding the word until that output frees.

---
 rtl/fifo_rr_router.sv | 164 ++++++++++++++++
 tb/tb_fifo_rr_router.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_router.sv
// fifo_rr_router: round-robin consumer of four input FIFOs that routes each
// word to one of four output FIFOs. The output FIFO is chosen by the top two
// bits of the word. A word whose target output is paused (almost full) is held
// until that output frees up. No other input is served while a word is held.
//
// state | meaning
// ------+-------------------------------------------------------------------
// IDLE  | arbitrate among non-empty inputs; launch a one-cycle pop
// POP   | in_pop is high this cycle; input FIFO presents the word next cycle
// RECV  | capture the word; push it now, or park it in HOLD if target paused
// HOLD  | wait for the target output to unpause, then push the held word
module fifo_rr_router #(
    parameter int DATA_SIZE = 12,
    parameter int CNT_SIZE  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           in_empty,
    input  logic [DATA_SIZE-1:0] in_data0,
    input  logic [DATA_SIZE-1:0] in_data1,
    input  logic [DATA_SIZE-1:0] in_data2,
    input  logic [DATA_SIZE-1:0] in_data3,
    output logic [3:0]           in_pop,
    input  logic [3:0]           out_pause,
    output logic [3:0]           out_push,
    output logic [DATA_SIZE-1:0] out_data,
    output logic [1:0]           grant,
    output logic                 busy,
    output logic [CNT_SIZE-1:0]  routed_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        RECV = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t                 state, state_nxt;
    logic [DATA_SIZE-1:0]   hold, hold_nxt;
    logic [3:0]             in_pop_nxt;
    logic [3:0]             out_push_nxt;
    logic [DATA_SIZE-1:0]   out_data_nxt;
    logic [1:0]             grant_nxt;
    logic [CNT_SIZE-1:0]    routed_cnt_nxt;

    logic [1:0]             rr_sel;
    logic [1:0]             rr_cand;
    logic                   rr_found;
    logic [DATA_SIZE-1:0]   in_word;
    logic [1:0]             in_dest;
    logic [1:0]             hold_dest;

    // Word presented by the input FIFO that was last granted.
    always_comb begin
        in_word = in_data0;
        case (grant)
            2'd0: in_word = in_data0;
            2'd1: in_word = in_data1;
            2'd2: in_word = in_data2;
            2'd3: in_word = in_data3;
            default: in_word = in_data0;
        endcase
    end

    assign in_dest   = in_word[DATA_SIZE-1 -: 2];
    assign hold_dest = hold[DATA_SIZE-1 -: 2];
    assign busy      = (state != IDLE);

    // Round-robin pick: scan grant+1 .. grant+4 (mod 4); the last-served port
    // is checked last so every requester gets a turn.
    always_comb begin
        rr_sel   = grant;
        rr_cand  = grant;
        rr_found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            rr_cand = grant + 2'(i);
            if (!rr_found && !in_empty[rr_cand]) begin
                rr_sel   = rr_cand;
                rr_found = 1'b1;
            end
        end
    end

    // Next-state and next-output logic; strobes default low so each pulse
    // lasts exactly one cycle.
    always_comb begin
        state_nxt      = state;
        hold_nxt       = hold;
        in_pop_nxt     = 4'b0000;
        out_push_nxt   = 4'b0000;
        out_data_nxt   = out_data;
        grant_nxt      = grant;
        routed_cnt_nxt = routed_cnt;

        case (state)
            IDLE: begin
                if (rr_found) begin
                    grant_nxt  = rr_sel;
                    in_pop_nxt = 4'b0001 << rr_sel;
                    state_nxt  = POP;
                end
            end

            POP: begin
                state_nxt = RECV;
            end

            RECV: begin
                hold_nxt = in_word;
                if (!out_pause[in_dest]) begin
                    out_push_nxt   = 4'b0001 << in_dest;
                    out_data_nxt   = in_word;
                    routed_cnt_nxt = routed_cnt + CNT_SIZE'(1);
                    state_nxt      = IDLE;
                end else begin
                    state_nxt = HOLD;
                end
            end

            HOLD: begin
                if (!out_pause[hold_dest]) begin
                    out_push_nxt   = 4'b0001 << hold_dest;
                    out_data_nxt   = hold;
                    routed_cnt_nxt = routed_cnt + CNT_SIZE'(1);
                    state_nxt      = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register; reset discards any popped or held word at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Registered outputs and datapath; grant resets to 3 so port 0 wins first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold       <= '0;
            in_pop     <= 4'b0000;
            out_push   <= 4'b0000;
            out_data   <= '0;
            grant      <= 2'd3;
            routed_cnt <= '0;
        end else begin
            hold       <= hold_nxt;
            in_pop     <= in_pop_nxt;
            out_push   <= out_push_nxt;
            out_data   <= out_data_nxt;
            grant      <= grant_nxt;
            routed_cnt <= routed_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_rr_router.sv
// Directed bench for fifo_rr_router. Inputs change and outputs are sampled on
// the falling clock edge, midway between the rising edges the DUT acts on.
module tb_fifo_rr_router;

    localparam int DW = 12;
    localparam int CW = 4;

    logic          clk;
    logic          reset;
    logic [3:0]    in_empty;
    logic [DW-1:0] in_data0, in_data1, in_data2, in_data3;
    logic [3:0]    in_pop;
    logic [3:0]    out_pause;
    logic [3:0]    out_push;
    logic [DW-1:0] out_data;
    logic [1:0]    grant;
    logic          busy;
    logic [CW-1:0] routed_cnt;

    int checks = 0;
    int errors = 0;

    fifo_rr_router #(.DATA_SIZE(DW), .CNT_SIZE(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_empty   (in_empty),
        .in_data0   (in_data0),
        .in_data1   (in_data1),
        .in_data2   (in_data2),
        .in_data3   (in_data3),
        .in_pop     (in_pop),
        .out_pause  (out_pause),
        .out_push   (out_push),
        .out_data   (out_data),
        .grant      (grant),
        .busy       (busy),
        .routed_cnt (routed_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [DW-1:0] rr_data [4];
        rr_data[0] = 12'h0A0;
        rr_data[1] = 12'h5A1;
        rr_data[2] = 12'hAA2;
        rr_data[3] = 12'hFA3;

        reset     = 1'b1;
        in_empty  = 4'b1111;
        out_pause = 4'b0000;
        in_data0  = '0;
        in_data1  = '0;
        in_data2  = '0;
        in_data3  = '0;

        // reset values
        step(1);
        check("rst_in_pop",   in_pop, 4'b0000);
        check("rst_out_push", out_push, 4'b0000);
        check("rst_out_data", out_data, 12'h000);
        check("rst_grant",    grant, 2'd3);
        check("rst_busy",     busy, 1'b0);
        check("rst_cnt",      routed_cnt, 4'd0);
        reset = 1'b0;

        // all inputs empty for 10 cycles
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("idle_in_pop",   in_pop, 4'b0000);
            check("idle_out_push", out_push, 4'b0000);
            check("idle_busy",     busy, 1'b0);
            check("idle_grant",    grant, 2'd3);
        end

        // single word from input 2 to output 3
        in_data2 = 12'hC5A;
        in_empty = 4'b1011;
        step(1);
        check("t2_pop",   in_pop, 4'b0100);
        check("t2_grant", grant, 2'd2);
        check("t2_busy",  busy, 1'b1);
        check("t2_push0", out_push, 4'b0000);
        in_empty = 4'b1111;
        step(1);
        check("t2_pop_off", in_pop, 4'b0000);
        check("t2_push1",   out_push, 4'b0000);
        step(1);
        check("t2_push",  out_push, 4'b1000);
        check("t2_data",  out_data, 12'hC5A);
        check("t2_cnt",   routed_cnt, 4'd1);
        check("t2_pop2",  in_pop, 4'b0000);
        step(1);
        check("t2_push_off", out_push, 4'b0000);
        check("t2_idle",     busy, 1'b0);

        // reset pulse so round-robin restarts from port 0
        reset = 1'b1;
        #1;
        check("rr_rst_grant", grant, 2'd3);
        check("rr_rst_cnt",   routed_cnt, 4'd0);
        step(1);
        reset = 1'b0;

        // all four inputs held non-empty
        in_data0 = rr_data[0];
        in_data1 = rr_data[1];
        in_data2 = rr_data[2];
        in_data3 = rr_data[3];
        in_empty = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            step(1);
            check("rr_pop",      in_pop, 4'b0001 << (k % 4));
            check("rr_grant",    grant, k % 4);
            check("rr_nopush",   out_push, 4'b0000);
            step(1);
            check("rr_mid_pop",  in_pop, 4'b0000);
            check("rr_mid_push", out_push, 4'b0000);
            step(1);
            check("rr_push",     out_push, 4'b0001 << (k % 4));
            check("rr_data",     out_data, rr_data[k % 4]);
            check("rr_cnt",      routed_cnt, k + 1);
            check("rr_push_pop", in_pop, 4'b0000);
            if (k == 4) in_empty = 4'b1111;
        end

        // paused output: word 4FF from port 1 to output 1, others stay ready
        in_data1  = 12'h4FF;
        in_empty  = 4'b1101;
        out_pause = 4'b0010;
        step(1);
        check("h_pop",   in_pop, 4'b0010);
        check("h_grant", grant, 2'd1);
        in_empty = 4'b1010;
        step(1);
        check("h_pop_off", in_pop, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("h_wait_push",  out_push, 4'b0000);
            check("h_wait_pop",   in_pop, 4'b0000);
            check("h_wait_busy",  busy, 1'b1);
            check("h_wait_grant", grant, 2'd1);
        end
        out_pause = 4'b0000;
        step(1);
        check("h_push", out_push, 4'b0010);
        check("h_data", out_data, 12'h4FF);
        check("h_cnt",  routed_cnt, 4'd6);
        in_empty = 4'b1111;
        step(1);
        check("h_push_off", out_push, 4'b0000);
        check("h_idle",     busy, 1'b0);

        // reset while holding a word for paused output 2
        in_data2  = 12'hB33;
        in_empty  = 4'b1011;
        out_pause = 4'b0100;
        step(1);
        check("rh_pop", in_pop, 4'b0100);
        in_empty = 4'b1111;
        step(2);
        check("rh_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        check("rh_busy0", busy, 1'b0);
        check("rh_grant", grant, 2'd3);
        check("rh_push",  out_push, 4'b0000);
        check("rh_cnt",   routed_cnt, 4'd0);
        out_pause = 4'b0000;
        step(1);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("rh_after_push", out_push, 4'b0000);
            check("rh_after_data", out_data, 12'h000);
        end

        // 16 words through a 4-bit counter: wraps to 0
        in_data0 = 12'h0A0;
        in_empty = 4'b1110;
        for (int k = 1; k <= 16; k++) begin
            step(3);
            check("wr_push", out_push, 4'b0001);
            check("wr_cnt",  routed_cnt, k % 16);
            if (k == 16) in_empty = 4'b1111;
        end
        step(2);
        check("wr_final_cnt", routed_cnt, 4'd0);
        check("wr_final_busy", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
